timer_sequencer: RTL and testbench
==================================

Name: timer_sequencer

Overview:
- Upstream command stage for the one-shot 16-bit down-counting timer (load/cycles in, busy out).
- Accepts tagged interval requests over a valid/ready handshake and buffers them in a small FIFO.
- Issues them to the timer one at a time, never loading while the timer is busy and never loading a zero count.
- Reports completion of each interval with its tag and an error flag.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- CYC_W, 16, interval width; matches the timer's cycles port.
- TAG_W, 4, request tag width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept; equals !full, registered
- req_cycles  in  CYC_W  requested interval length in cycles
- req_tag  in  TAG_W  request identifier
- tmr_load  out  1  one-cycle load strobe to the timer
- tmr_cycles  out  CYC_W  count presented with tmr_load
- tmr_busy  in  1  timer busy
- done  out  1  one-cycle completion pulse
- done_tag  out  TAG_W  tag of the completed request
- done_err  out  1  qualifies done: zero count, or timer failed to start
- pending  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-high. FIFO emptied; state IDLE.
- Output reset values: req_ready=1, tmr_load=0, tmr_cycles=0, done=0, done_tag=0, done_err=0, pending=0.
- Reset mid-operation aborts the in-flight request with no done pulse. The timer is reset by the same signal.
- Push: FIFO writes on req_valid && req_ready.
- req_ready is registered as !full. req_valid while full is ignored. Push and pop in the same cycle are allowed; occupancy is unchanged.
- Handshake: a request is accepted when the push condition holds. The request need not be held stable after acceptance.
- State machine, all outputs registered:
  - IDLE: if !empty && !tmr_busy, pop the head into cur_cycles/cur_tag. If cur_cycles==0, go to DONE with err=1. Otherwise go to LOAD. If tmr_busy is high (external load), wait in IDLE.
  - LOAD: tmr_load=1 and tmr_cycles=cur_cycles for exactly one cycle; go to ARM.
  - ARM: the timer has latched the count. If tmr_busy, go to WAIT. Otherwise go to DONE with err=1.
  - WAIT: hold until !tmr_busy, then go to DONE with err=0.
  - DONE: done=1 with done_tag=cur_tag and done_err=err for one cycle; return to IDLE.
- tmr_load is never high in two consecutive cycles. tmr_load is never high while tmr_busy is high.
- tmr_cycles is driven only in LOAD and holds 0 otherwise.
- Latency for count N≥1, with tmr_load in cycle L:
  - busy is seen in L+1.
  - busy falls in L+1+N.
  - done is high in L+2+N.
  - Request acceptance to tmr_load: 2 cycles from an empty, idle state.
- Back-to-back requests: the next tmr_load occurs no earlier than 2 cycles after the previous done (DONE→IDLE→LOAD).
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy counter range is 0..DEPTH.

Optional Feature:
- Macro: TIMER_SEQUENCER_FORMAL_EN.
- With the macro defined, the block includes assertions:
  - tmr_load is never high while tmr_busy is high.
  - tmr_cycles is non-zero whenever tmr_load is high.
  - done implies $past(state)==WAIT or an err path.
  - pending ≤ DEPTH.
  - No push when full.
- It also includes covers: done with err=0; done with err=1; FIFO full.
- The macro also adds an environment constraint that the tmr_busy input obeys the timer's protocol.
- Without the macro, none of this logic is elaborated.

Decomposition:
- Package timer_seq_pkg:
  - state enum (IDLE, LOAD, ARM, WAIT, DONE);
  - default widths CYC_W=16 and TAG_W=4.
- Sub-module: timer_seq_fifo, a parameterised synchronous FIFO with push/pop, full/empty and count, instantiated once.

Test Plan:
- Reset, then a single request (cycles=5, tag=3) → tmr_load at cycle 2 after acceptance with tmr_cycles=5; done with done_tag=3 and done_err=0 exactly 7 cycles after tmr_load.
- Push 4 requests (1, 2, 3, 4) back-to-back → req_ready falls after the 4th; loads are issued in order with no overlap against busy; 4 done pulses carry tags in order.
- Request cycles=0, tag=9 → no tmr_load; done with done_tag=9 and done_err=1, 2 cycles after acceptance.
- tmr_busy held high externally for 10 cycles while a request is queued → no tmr_load until busy falls; then normal completion.
- Reset asserted during WAIT with 2 entries queued → no done pulse; pending=0; req_ready=1 the next cycle.
- Timer model that never raises busy → ARM detects it; done_err=1; sequencer proceeds to the next entry.

Source files
------------

// File: rtl/timer_seq_pkg.sv
// Shared widths and FSM state encodings for the timer sequencer.
package timer_seq_pkg;
    localparam int CYC_W_DEF = 16;
    localparam int TAG_W_DEF = 4;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_ARM  = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
endpackage

// File: rtl/timer_seq_fifo.sv
// Synchronous FIFO with registered full/empty flags; the head entry is visible on rdata.
module timer_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_next;
    logic          do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Flags come from the next count so they are plain flops, not decodes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end
endmodule

// File: rtl/timer_sequencer.sv
// Queues tagged interval requests and issues them one at a time to a one-shot timer.
// Define TIMER_SEQUENCER_FORMAL_EN to elaborate the assertions, covers and timer assumption.
module timer_sequencer
    import timer_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CYC_W = CYC_W_DEF,
    parameter int TAG_W = TAG_W_DEF,
    localparam int PW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CYC_W-1:0] req_cycles,
    input  logic [TAG_W-1:0] req_tag,
    output logic             tmr_load,
    output logic [CYC_W-1:0] tmr_cycles,
    input  logic             tmr_busy,
    output logic             done,
    output logic [TAG_W-1:0] done_tag,
    output logic             done_err,
    output logic [PW-1:0]    pending
);
    logic [2:0]             state;
    logic [TAG_W-1:0]       cur_tag;
    logic                   fifo_full, fifo_empty, push, pop;
    logic [CYC_W+TAG_W-1:0] head;
    logic [CYC_W-1:0]       head_cycles;
    logic [TAG_W-1:0]       head_tag;

    assign req_ready   = !fifo_full;
    assign push        = req_valid && req_ready;
    assign pop         = (state == ST_IDLE) && !fifo_empty && !tmr_busy;
    assign head_cycles = head[TAG_W +: CYC_W];
    assign head_tag    = head[TAG_W-1:0];

    timer_seq_fifo #(.DEPTH(DEPTH), .W(CYC_W + TAG_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata ({req_cycles, req_tag}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (pending)
    );

    // Strobes default low each cycle; each state sets what it drives.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cur_tag    <= '0;
            tmr_load   <= 1'b0;
            tmr_cycles <= '0;
            done       <= 1'b0;
            done_tag   <= '0;
            done_err   <= 1'b0;
        end else begin
            tmr_load   <= 1'b0;
            tmr_cycles <= '0;
            done       <= 1'b0;
            done_tag   <= '0;
            done_err   <= 1'b0;
            case (state)
                ST_IDLE: if (pop) begin
                    cur_tag <= head_tag;
                    if (head_cycles == '0) begin
                        state    <= ST_DONE;
                        done     <= 1'b1;
                        done_tag <= head_tag;
                        done_err <= 1'b1;
                    end else begin
                        state      <= ST_LOAD;
                        tmr_load   <= 1'b1;
                        tmr_cycles <= head_cycles;
                    end
                end
                ST_LOAD: state <= ST_ARM;
                // A timer that is not busy right after a load never started.
                ST_ARM: if (tmr_busy) begin
                    state <= ST_WAIT;
                end else begin
                    state    <= ST_DONE;
                    done     <= 1'b1;
                    done_tag <= cur_tag;
                    done_err <= 1'b1;
                end
                ST_WAIT: if (!tmr_busy) begin
                    state    <= ST_DONE;
                    done     <= 1'b1;
                    done_tag <= cur_tag;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef TIMER_SEQUENCER_FORMAL_EN
    // The timer reports busy in the cycle after every non-zero load.
    assume property (@(posedge clk) disable iff (reset) $past(tmr_load) |-> tmr_busy);

    a_load_idle:  assert property (@(posedge clk) disable iff (reset) tmr_load |-> !tmr_busy);
    a_load_nz:    assert property (@(posedge clk) disable iff (reset) tmr_load |-> tmr_cycles != '0);
    a_done_src:   assert property (@(posedge clk) disable iff (reset)
                                   done |-> ($past(state) == ST_WAIT || done_err));
    a_pending:    assert property (@(posedge clk) disable iff (reset) pending <= PW'(DEPTH));
    a_no_ovf:     assert property (@(posedge clk) disable iff (reset) fifo_full |-> !push);

    c_done_ok:    cover property (@(posedge clk) done && !done_err);
    c_done_err:   cover property (@(posedge clk) done && done_err);
    c_full:       cover property (@(posedge clk) fifo_full);
`endif
endmodule

// File: tb/tb_timer_sequencer.sv
// Scoreboard bench: stimulus queues expected loads/completions, a negedge monitor checks them.
module tb_timer_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_cycles;
    logic [3:0]  req_tag;
    logic        tmr_load;
    logic [15:0] tmr_cycles;
    logic        tmr_busy;
    logic        done;
    logic [3:0]  done_tag;
    logic        done_err;
    logic [2:0]  pending;

    typedef struct packed {
        logic [3:0] tag;
        logic       err;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] load_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int load_cyc = 0;
    int done_cyc = 0;
    int n_loads  = 0;
    int acc_cyc  = 0;
    bit prev_load = 1'b0;

    // Simple one-shot timer environment: busy for N cycles after a load.
    logic [15:0] tcnt;
    logic        ext_busy = 1'b0;
    logic        dead     = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (reset)                         tcnt <= '0;
        else if (tmr_load && !dead)        tcnt <= tmr_cycles;
        else if (tcnt != '0)               tcnt <= tcnt - 16'd1;
    end
    assign tmr_busy = (tcnt != '0) || ext_busy;

    timer_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cycles (req_cycles),
        .req_tag    (req_tag),
        .tmr_load   (tmr_load),
        .tmr_cycles (tmr_cycles),
        .tmr_busy   (tmr_busy),
        .done       (done),
        .done_tag   (done_tag),
        .done_err   (done_err),
        .pending    (pending)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (tmr_load) begin
                load_cyc = cyc;
                n_loads++;
                check("load_while_busy", int'(tmr_busy), 0);
                check("load_back_to_back", int'(prev_load), 0);
                if (load_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_load: got cycles=%0d expected none", tmr_cycles);
                end else begin
                    check("load_cycles", int'(tmr_cycles), int'(load_q.pop_front()));
                end
            end else begin
                check("tmr_cycles_idle", int'(tmr_cycles), 0);
            end
            prev_load = tmr_load;
            if (done) begin
                exp_t e;
                done_cyc = cyc;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got tag=%0d expected none", done_tag);
                end else begin
                    e = exp_q.pop_front();
                    check("done_tag", int'(done_tag), int'(e.tag));
                    check("done_err", int'(done_err), int'(e.err));
                end
            end
        end
    end

    task automatic send(input logic [15:0] c, input logic [3:0] t, input bit err);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_cycles = c; req_tag = t;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_ready_timeout", int'(req_ready), 1);
        acc_cyc = cyc;
        exp_q.push_back('{tag: t, err: err});
        if (c != 16'd0) load_q.push_back(c);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || load_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", exp_q.size() + load_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved;
        int rel;
        reset = 1'b1; req_valid = 1'b0; req_cycles = '0; req_tag = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", int'(req_ready), 1);
        check("rst_pending", int'(pending), 0);
        check("rst_tmr_load", int'(tmr_load), 0);
        check("rst_tmr_cycles", int'(tmr_cycles), 0);
        check("rst_done", int'(done), 0);
        check("rst_done_tag", int'(done_tag), 0);
        check("rst_done_err", int'(done_err), 0);
        reset = 1'b0;

        // Single request: load 2 cycles after accept, done 7 cycles after load.
        send(16'd5, 4'd3, 1'b0);
        drain();
        check("t1_accept_to_load", load_cyc - acc_cyc, 2);
        check("t1_load_to_done", done_cyc - load_cyc, 7);

        // Fill the FIFO while the timer is externally busy, then try a 5th push.
        @(negedge clk) ext_busy = 1'b1;
        send(16'd1, 4'd1, 1'b0);
        send(16'd2, 4'd2, 1'b0);
        send(16'd3, 4'd3, 1'b0);
        send(16'd4, 4'd4, 1'b0);
        @(negedge clk);
        check("full_req_ready", int'(req_ready), 0);
        check("full_pending", int'(pending), 4);
        req_valid = 1'b1; req_cycles = 16'd7; req_tag = 4'd15;
        @(negedge clk);
        req_valid = 1'b0;
        check("full_push_ignored", int'(pending), 4);
        ext_busy = 1'b0;
        drain();
        check("full_pending_after", int'(pending), 0);

        // Zero count: no load, error completion 2 cycles after accept.
        saved = n_loads;
        send(16'd0, 4'd9, 1'b1);
        drain();
        check("zero_no_load", n_loads, saved);
        check("zero_accept_to_done", done_cyc - acc_cyc, 2);

        // External busy blocks loading until it falls.
        @(negedge clk) ext_busy = 1'b1;
        saved = n_loads;
        send(16'd6, 4'd5, 1'b0);
        repeat (10) @(negedge clk);
        check("ext_busy_no_load", n_loads, saved);
        rel = cyc;
        ext_busy = 1'b0;
        drain();
        check("ext_busy_release_to_load", load_cyc - rel, 1);

        // Reset during WAIT with two entries queued.
        send(16'd20, 4'd6, 1'b0);
        send(16'd2, 4'd7, 1'b0);
        send(16'd3, 4'd8, 1'b0);
        repeat (6) @(negedge clk);
        check("pre_reset_pending", int'(pending), 2);
        reset = 1'b1;
        exp_q.delete();
        load_q.delete();
        @(negedge clk);
        reset = 1'b0;
        check("post_reset_pending", int'(pending), 0);
        check("post_reset_ready", int'(req_ready), 1);
        check("post_reset_done", int'(done), 0);
        repeat (30) @(negedge clk);
        send(16'd2, 4'd13, 1'b0);
        drain();

        // Timer that never starts: ARM flags error, next entry still runs.
        @(negedge clk) dead = 1'b1;
        send(16'd4, 4'd10, 1'b1);
        send(16'd3, 4'd11, 1'b1);
        drain();
        @(negedge clk) dead = 1'b0;
        send(16'd2, 4'd12, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
